// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state and access-size types, and the funct3 size decode.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Undefined encodings (011, 11x) fall through to a plain word access.
    function automatic lsu_size_e decode_size(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_BU: decode_size = SZ_B;
            LSU_H, LSU_HU: decode_size = SZ_H;
            default:       decode_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data-path for the LSU: store lane replication and byte enables,
// load lane extraction with sign/zero extension, and natural-alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  type_access_i,
    input  logic [1:0]  addr_lsb_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] ld_data_o
);

    lsu_size_e   size;
    logic        is_signed;
    logic [31:0] rdata_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        size         = decode_size(type_access_i);
        is_signed    = ~type_access_i[2];
        rdata_shift  = rdata_i >> {addr_lsb_i, 3'b000};
        byte_sel     = rdata_shift[7:0];
        half_sel     = addr_lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_lane_o = wdata_i;
        ld_data_o    = rdata_i;

        case (size)
            SZ_B: begin
                be_o         = 4'b0001 << addr_lsb_i;
                wdata_lane_o = {4{wdata_i[7:0]}};
                ld_data_o    = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                misaligned_o = addr_lsb_i[0];
                be_o         = 4'b0011 << addr_lsb_i;
                wdata_lane_o = {2{wdata_i[15:0]}};
                ld_data_o    = {{16{is_signed & half_sel[15]}}, half_sel};
            end
            default: begin
                misaligned_o = |addr_lsb_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: runs one req/gnt/rvalid data-memory transaction per memory
// instruction held in EX/MEM, stalling the pipeline until it completes.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_mem_rw,
    input  logic [2:0]        i_type_access,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic [31:0]       o_ld_data,
    output logic              o_done,
    output logic              o_misaligned,
    output logic              o_bus_err,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    output logic [3:0]        o_dmem_be,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        type_q, type_d;
    logic              rw_q, rw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;

    logic [2:0]  cur_type;
    logic [1:0]  cur_lsb;
    logic        al_misaligned;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;
    logic        in_req;
    logic        timeout;

    // In IDLE the alignment check must see the incoming op; afterwards the latched one.
    assign cur_type = (state_q == IDLE) ? i_type_access : type_q;
    assign cur_lsb  = (state_q == IDLE) ? i_addr[1:0]   : addr_q[1:0];

    lsu_align u_align (
        .type_access_i (cur_type),
        .addr_lsb_i    (cur_lsb),
        .wdata_i       (wdata_q),
        .rdata_i       (i_dmem_rdata),
        .misaligned_o  (al_misaligned),
        .be_o          (al_be),
        .wdata_lane_o  (al_wdata),
        .ld_data_o     (al_ld_data)
    );

    assign timeout = (cnt_q == CNT_LAST);

    // NOTE: next-state logic uses blocking (=) assignments; only the registers below use <=.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        type_d       = type_q;
        rw_d         = rw_q;
        cnt_d        = '0;
        ld_data_d    = ld_data_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req) begin
                    addr_d    = i_addr;
                    wdata_d   = i_wdata;
                    type_d    = i_type_access;
                    rw_d      = i_mem_rw;
                    ld_data_d = '0;
                    if (al_misaligned) begin
                        state_d      = DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_dmem_gnt) begin
                    state_d = rw_q ? DONE : RESP;
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_dmem_rvalid) begin
                    state_d   = DONE;
                    ld_data_d = al_ld_data;
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written only with non-blocking (<=) assignments.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            type_q       <= '0;
            rw_q         <= 1'b0;
            cnt_q        <= '0;
            ld_data_q    <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            type_q       <= type_d;
            rw_q         <= rw_d;
            cnt_q        <= cnt_d;
            ld_data_q    <= ld_data_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign in_req       = (state_q == REQ);
    assign o_stall      = i_req & (state_q != DONE);
    assign o_done       = (state_q == DONE);
    assign o_ld_data    = o_done ? ld_data_q : '0;
    assign o_misaligned = misaligned_q;
    assign o_bus_err    = bus_err_q;

    assign o_dmem_req   = in_req;
    assign o_dmem_we    = in_req & rw_q;
    assign o_dmem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign o_dmem_wdata = in_req ? al_wdata : '0;
    assign o_dmem_be    = in_req ? al_be : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with a short bus timeout.
module tb_mem_stage_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req;
    logic        i_mem_rw;
    logic [2:0]  i_type_access;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_ld_data;
    logic        o_done;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int stalls;

    always #5 i_clk = ~i_clk;

    mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_req         (i_req),
        .i_mem_rw      (i_mem_rw),
        .i_type_access (i_type_access),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_ld_data     (o_ld_data),
        .o_done        (o_done),
        .o_misaligned  (o_misaligned),
        .o_bus_err     (o_bus_err),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_gnt    (i_dmem_gnt),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start(input logic rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        i_req         = 1'b1;
        i_mem_rw      = rw;
        i_type_access = f3;
        i_addr        = a;
        i_wdata       = d;
    endtask

    // Load with gnt on the first REQ cycle and rvalid on the next; leaves the DUT in DONE.
    task automatic load_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        start(1'b0, f3, a, 32'h0);
        step();
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = rd;
        step();
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0;
        i_req = 1'b0; i_mem_rw = 1'b0; i_type_access = 3'b0;
        i_addr = 32'h0; i_wdata = 32'h0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        step(); step();
        chk("rst_stall",  {31'b0, o_stall},      32'h0);
        chk("rst_done",   {31'b0, o_done},       32'h0);
        chk("rst_req",    {31'b0, o_dmem_req},   32'h0);
        chk("rst_ld",     o_ld_data,             32'h0);
        chk("rst_flags",  {30'b0, o_misaligned, o_bus_err}, 32'h0);
        i_reset = 1'b1;
        step();

        // SW 0x104: gnt on first REQ cycle, two stall cycles
        stalls = 0;
        start(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        #1;
        if (o_stall) stalls++;
        chk("sw_idle_req", {31'b0, o_dmem_req}, 32'h0);
        step();
        chk("sw_req",   {31'b0, o_dmem_req}, 32'h1);
        chk("sw_we",    {31'b0, o_dmem_we},  32'h1);
        chk("sw_addr",  o_dmem_addr,         32'h0000_0104);
        chk("sw_wdata", o_dmem_wdata,        32'hDEAD_BEEF);
        chk("sw_be",    {28'b0, o_dmem_be},  32'hF);
        i_dmem_gnt = 1'b1;
        #1;
        if (o_stall) stalls++;
        step();
        i_dmem_gnt = 1'b0;
        chk("sw_done",   {31'b0, o_done},  32'h1);
        chk("sw_nostall", {31'b0, o_stall}, 32'h0);
        chk("sw_stalls", stalls, 32'd2);
        i_req = 1'b0;
        step();
        chk("sw_done_pulse", {31'b0, o_done}, 32'h0);

        // SB 0x203 data A5: replicated lane, top byte enable
        start(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5);
        step();
        chk("sb_wdata", o_dmem_wdata,        32'hA5A5_A5A5);
        chk("sb_be",    {28'b0, o_dmem_be},  32'h8);
        chk("sb_addr",  o_dmem_addr,         32'h0000_0200);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        chk("sb_done", {31'b0, o_done}, 32'h1);
        i_req = 1'b0;
        step();

        // SH 0x106: upper half lane
        start(1'b1, 3'b001, 32'h0000_0106, 32'h1234_ABCD);
        step();
        chk("sh_wdata", o_dmem_wdata,       32'hABCD_ABCD);
        chk("sh_be",    {28'b0, o_dmem_be}, 32'hC);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        i_req = 1'b0;
        step();

        // LB / LBU at 0x102, lane 2 holds 0x80
        load_op(3'b000, 32'h0000_0102, 32'h0080_0000);
        chk("lb_done", {31'b0, o_done}, 32'h1);
        chk("lb_data", o_ld_data, 32'hFFFF_FF80);
        i_req = 1'b0;
        step();
        load_op(3'b100, 32'h0000_0102, 32'h0080_0000);
        chk("lbu_data", o_ld_data, 32'h0000_0080);
        i_req = 1'b0;
        step();

        // LH / LHU upper half
        load_op(3'b001, 32'h0000_0102, 32'h8001_1234);
        chk("lh_data", o_ld_data, 32'hFFFF_8001);
        i_req = 1'b0;
        step();
        load_op(3'b101, 32'h0000_0102, 32'hBEEF_0000);
        chk("lhu_data", o_ld_data, 32'h0000_BEEF);
        i_req = 1'b0;
        step();

        // Undefined funct3 011 behaves as LW
        load_op(3'b011, 32'h0000_0108, 32'h1234_5678);
        chk("l011_data", o_ld_data, 32'h1234_5678);
        i_req = 1'b0;
        step();

        // LH 0x101 misaligned: DONE next cycle, no bus request
        start(1'b0, 3'b001, 32'h0000_0101, 32'h0);
        #1;
        chk("lhm_idle_stall", {31'b0, o_stall}, 32'h1);
        step();
        chk("lhm_done", {31'b0, o_done},       32'h1);
        chk("lhm_mis",  {31'b0, o_misaligned}, 32'h1);
        chk("lhm_req",  {31'b0, o_dmem_req},   32'h0);
        chk("lhm_ld",   o_ld_data,             32'h0);
        i_req = 1'b0;
        step();
        chk("lhm_mis_pulse", {31'b0, o_misaligned}, 32'h0);

        // Stray gnt/rvalid while idle are ignored
        i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
        step();
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
        chk("stray_done", {31'b0, o_done},     32'h0);
        chk("stray_req",  {31'b0, o_dmem_req}, 32'h0);

        // LW with gnt but no rvalid: timeout after 8 cycles in REQ+RESP
        start(1'b0, 3'b010, 32'h0000_010C, 32'h0);
        cyc = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (o_done) break;
            cyc++;
            i_dmem_gnt = o_dmem_req;
        end
        i_dmem_gnt = 1'b0;
        chk("to_done",   {31'b0, o_done},     32'h1);
        chk("to_cycles", cyc,                 32'd8);
        chk("to_buserr", {31'b0, o_bus_err},  32'h1);
        chk("to_ld",     o_ld_data,           32'h0);
        chk("to_req",    {31'b0, o_dmem_req}, 32'h0);
        i_req = 1'b0;
        step();
        chk("to_buserr_pulse", {31'b0, o_bus_err}, 32'h0);

        // Flush: i_req drops while in REQ, access still completes
        start(1'b1, 3'b010, 32'h0000_0114, 32'h5555_AAAA);
        step();
        i_req = 1'b0;
        #1;
        chk("fl_stall", {31'b0, o_stall},    32'h0);
        chk("fl_req",   {31'b0, o_dmem_req}, 32'h1);
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        chk("fl_done", {31'b0, o_done}, 32'h1);
        step();

        // Reset in RESP, late rvalid afterwards must be ignored
        start(1'b0, 3'b010, 32'h0000_0110, 32'h0);
        step();
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        i_req = 1'b0;
        i_reset = 1'b0;
        #1;
        chk("rr_req",  {31'b0, o_dmem_req}, 32'h0);
        chk("rr_done", {31'b0, o_done},     32'h0);
        step();
        i_reset = 1'b1;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hFFFF_FFFF;
        step();
        i_dmem_rvalid = 1'b0;
        chk("rr_late_done", {31'b0, o_done}, 32'h0);
        chk("rr_late_ld",   o_ld_data,       32'h0);
        step();
        chk("rr_idle_done", {31'b0, o_done},     32'h0);
        chk("rr_idle_req",  {31'b0, o_dmem_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
